// File: rtl/fp2bfp_packer.sv
// Packs a serial FP32 stream into block-floating-point groups: one shared (max) exponent
// plus a truncated, sign-magnitude mantissa per lane, handed off via valid/ready.
module fp2bfp_packer #(
    parameter int unsigned GRPSIZE    = 16,
    parameter int unsigned BFPEXPSIZE = 8,
    parameter int unsigned BFPMANSIZE = 4
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_fp_valid,
    output logic                             o_fp_ready,
    input  logic [31:0]                      i_fp,
    input  logic                             i_fp_last,
    output logic                             o_bfp_valid,
    input  logic                             i_bfp_ready,
    output logic [BFPEXPSIZE-1:0]            o_bfp_E,
    output logic [BFPMANSIZE*GRPSIZE-1:0]    o_bfp_M,
    output logic                             o_bfp_special
);

    localparam int unsigned IdxW = $clog2(GRPSIZE);
    localparam int unsigned CntW = IdxW + 1;
    localparam int unsigned MagW = BFPMANSIZE - 1;

    typedef enum logic [1:0] {StFill, StAlign, StEmit} state_e;

    state_e                          r_state;
    logic [31:0]                     r_lane [GRPSIZE];
    logic [CntW-1:0]                 r_cnt;
    logic [7:0]                      r_maxexp;
    logic                            r_special;

    logic                            w_accept;
    logic                            w_last_lane;
    logic [7:0]                      w_exp;
    logic [BFPMANSIZE*GRPSIZE-1:0]   w_mant;

    // Align one lane against the group exponent; magnitude is truncated toward zero.
    function automatic logic [BFPMANSIZE-1:0] f_lane(input logic [31:0] word,
                                                     input logic [7:0]  maxexp);
        logic [7:0]      e;
        logic [7:0]      sh;
        logic [MagW-1:0] full;
        logic [MagW-1:0] mag;
        e    = word[30:23];
        full = {1'b1, word[22 -: BFPMANSIZE-2]};
        sh   = maxexp - e;
        mag  = (sh >= 8'(MagW)) ? '0 : full >> sh;
        if (e == 8'd0) begin
            f_lane = '0;
        end else if (e == 8'hFF) begin
            f_lane = {word[31], {MagW{1'b1}}};
        end else if (mag == '0) begin
            f_lane = '0;
        end else begin
            f_lane = {word[31], mag};
        end
    endfunction

    assign o_fp_ready  = (r_state == StFill);
    assign w_accept    = i_fp_valid && o_fp_ready;
    assign w_last_lane = (r_cnt == CntW'(GRPSIZE - 1));
    assign w_exp       = i_fp[30:23];

    // Lanes beyond the accepted count belong to an earlier group and read as +0.
    always_comb begin
        w_mant = '0;
        for (int i = 0; i < int'(GRPSIZE); i++) begin
            if (CntW'(i) < r_cnt) begin
                w_mant[i*BFPMANSIZE +: BFPMANSIZE] = f_lane(r_lane[i], r_maxexp);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StFill;
            r_cnt         <= '0;
            r_maxexp      <= '0;
            r_special     <= 1'b0;
            o_bfp_valid   <= 1'b0;
            o_bfp_E       <= '0;
            o_bfp_M       <= '0;
            o_bfp_special <= 1'b0;
        end else begin
            unique case (r_state)
                StFill: begin
                    if (w_accept) begin
                        r_lane[r_cnt[IdxW-1:0]] <= i_fp;
                        r_cnt                   <= r_cnt + 1'b1;
                        if (w_exp == 8'hFF) begin
                            r_special <= 1'b1;
                        end else if (w_exp > r_maxexp) begin
                            r_maxexp <= w_exp;
                        end
                        if (i_fp_last || w_last_lane) begin
                            r_state <= StAlign;
                        end
                    end
                end
                StAlign: begin
                    o_bfp_E       <= BFPEXPSIZE'(r_maxexp);
                    o_bfp_M       <= w_mant;
                    o_bfp_special <= r_special;
                    o_bfp_valid   <= 1'b1;
                    r_state       <= StEmit;
                end
                StEmit: begin
                    if (i_bfp_ready) begin
                        o_bfp_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_maxexp    <= '0;
                        r_special   <= 1'b0;
                        r_state     <= StFill;
                    end
                end
                default: r_state <= StFill;
            endcase
        end
    end

endmodule
